mem_arbiter2: RTL

Two-port round-robin arbiter that shares the single byte-addressed, big-endian word memory between two requesters. Port 0 is the CPU control unit load/store/fetch path; port 1 is a DMA/IO master. It converts each requester's req/ack handshake into the memory's level-style en/rw/abus/dbus access. It holds the access for a fixed memory latency, then returns read data with a one-cycle ack.

---
 rtl/mem_arbiter2.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter2.sv
// mem_arbiter2: two-port round-robin arbiter sharing one byte-addressed,
// big-endian word memory between the CPU path (port 0) and a DMA/IO master
// (port 1). Each granted access holds m_en for MEM_LAT cycles, then the
// owner gets a one-cycle ack with read data or an address error flag.
// All outputs are registered from the current state, so they trail the
// state register by one cycle.
module mem_arbiter2 #(
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned MEM_SIZE = 128
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        rw0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic [31:0] rdata0,
    output logic        ack0,
    output logic        err0,
    input  logic        req1,
    input  logic        rw1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic [31:0] rdata1,
    output logic        ack1,
    output logic        err1,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic        m_en,
    output logic        m_rw,
    output logic [31:0] m_abus,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    // Highest legal word address; comparing against it avoids computing addr+3.
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(MEM_SIZE - 4);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Control state
    state_e              state_q,  state_d;
    logic                prio_q,   prio_d;
    logic                owner_q,  owner_d;
    logic                rw_q,     rw_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic                err_q,    err_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;

    // Registered outputs
    logic [1:0]          gnt_q,     gnt_d;
    logic                busy_q,    busy_d;
    logic                m_en_q,    m_en_d;
    logic                m_rw_q,    m_rw_d;
    logic [ADDR_W-1:0]   m_abus_q,  m_abus_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic                ack0_q,    ack0_d;
    logic                ack1_q,    ack1_d;
    logic                err0_q,    err0_d;
    logic                err1_q,    err1_d;
    logic [DATA_W-1:0]   rdata0_q,  rdata0_d;
    logic [DATA_W-1:0]   rdata1_q,  rdata1_d;

    // Arbitration helpers
    logic                win_vld;
    logic                win_port;
    logic                sel_rw;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                ack_pend;
    logic [DATA_W-1:0]   cap_data;

    // Pick the winning port and mux its request qualifiers.
    always_comb begin
        win_vld   = req0 | req1;
        win_port  = (req0 & req1) ? prio_q : req1;
        sel_rw    = win_port ? rw1 : rw0;
        sel_addr  = win_port ? addr1 : addr0;
        sel_wdata = win_port ? wdata1 : wdata0;
    end

    // While an ack is visible the finishing requester still holds req; skip
    // arbitration for that cycle so the same request is not granted twice.
    assign ack_pend = ack0_q | ack1_q;

    // Next-state logic: IDLE -> ACCESS (legal) or DONE (error), ACCESS -> DONE, DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (win_vld && !ack_pend) begin
                    owner_d = win_port;
                    prio_d  = ~win_port;
                    rw_d    = sel_rw;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    if (sel_addr <= ADDR_MAX) begin
                        err_d   = 1'b0;
                        cnt_d   = CNT_INIT;
                        state_d = ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read data is sampled at the edge closing the last m_en cycle.
    assign cap_data = (rw_q && !err_q) ? m_rdata : '0;

    // Output decode from the current state; becomes visible one cycle later.
    always_comb begin
        gnt_d     = 2'b00;
        busy_d    = (state_q != IDLE);
        m_en_d    = 1'b0;
        m_rw_d    = 1'b1;
        m_abus_d  = '0;
        m_wdata_d = '0;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        err0_d    = 1'b0;
        err1_d    = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;

        if (state_q != IDLE) begin
            gnt_d = owner_q ? 2'b10 : 2'b01;
        end

        if (state_q == ACCESS) begin
            m_en_d    = 1'b1;
            m_rw_d    = rw_q;
            m_abus_d  = addr_q;
            m_wdata_d = rw_q ? '0 : wdata_q;
        end

        if (state_q == DONE) begin
            if (owner_q) begin
                ack1_d   = 1'b1;
                err1_d   = err_q;
                rdata1_d = cap_data;
            end else begin
                ack0_d   = 1'b1;
                err0_d   = err_q;
                rdata0_d = cap_data;
            end
        end
    end

    // State and output registers; reset drops m_en without waiting for a clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            owner_q   <= 1'b0;
            rw_q      <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            gnt_q     <= 2'b00;
            busy_q    <= 1'b0;
            m_en_q    <= 1'b0;
            m_rw_q    <= 1'b1;
            m_abus_q  <= '0;
            m_wdata_q <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            owner_q   <= owner_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            m_en_q    <= m_en_d;
            m_rw_q    <= m_rw_d;
            m_abus_q  <= m_abus_d;
            m_wdata_q <= m_wdata_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign m_en    = m_en_q;
    assign m_rw    = m_rw_q;
    assign m_abus  = m_abus_q;
    assign m_wdata = m_wdata_q;
    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule
